cond_exec_stage: RTL and testbench

Execute-stage conditional-execution unit for the ARM-subset datapath, sitting directly downstream of the instruction decoder. It registers the decoder's control outputs into an execute-stage pipeline register, holds the architectural NZCV flag register, evaluates the instruction's 4-bit condition field against the current flags, and gates the write-enables and PC-source signal. It also counts retired and condition-failed instructions for lab performance reporting.

---
 rtl/arm_pkg.sv | 33 +++
 rtl/cond_exec_stage_if.sv | 34 +++
 rtl/cond_exec_stage_cond_check.sv | 37 +++
 rtl/cond_exec_stage.sv | 90 +++++++++
 tb/tb_cond_exec_stage.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared ARM-subset definitions: condition codes, NZCV flag bit positions
// and FlagW bit meanings used by the execute stage.
package arm_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW[FLAGW_NZ] updates N,Z; FlagW[FLAGW_CV] updates C,V.
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_exec_stage_if.sv
// Decoder-to-execute control bundle plus the gated execute-stage outputs.
// Handshake: in_valid qualifies the decoder fields on a rising edge; stall
// holds the stage, flush turns the incoming slot into a bubble.
interface cond_exec_if;
  logic       in_valid;
  logic       stall;
  logic       flush;
  logic [3:0] Cond;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       Shift;
  logic [1:0] FlagW;
  logic [3:0] ALUFlags;
  logic       ShiftCarry;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  modport master (
    output in_valid, stall, flush, Cond, PCS, RegW, MemW, NoWrite, Shift,
           FlagW, ALUFlags, ShiftCarry,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags
  );

  modport slave (
    input  in_valid, stall, flush, Cond, PCS, RegW, MemW, NoWrite, Shift,
           FlagW, ALUFlags, ShiftCarry,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags
  );
endinterface

// File: rtl/cond_exec_stage_cond_check.sv
// Combinational ARM condition-field evaluator against the NZCV flags.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       condpass
);
  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    condpass = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: condpass = z;
      COND_NE: condpass = ~z;
      COND_CS: condpass = c;
      COND_CC: condpass = ~c;
      COND_MI: condpass = n;
      COND_PL: condpass = ~n;
      COND_VS: condpass = v;
      COND_VC: condpass = ~v;
      COND_HI: condpass = c & ~z;
      COND_LS: condpass = ~c | z;
      COND_GE: condpass = (n == v);
      COND_LT: condpass = (n != v);
      COND_GT: condpass = ~z & (n == v);
      COND_LE: condpass = z | (n != v);
      COND_AL: condpass = 1'b1;
      default: condpass = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage pipeline register, NZCV flag register, condition gating of
// write-enables/PC source, and retired/squashed instruction counters.
module cond_exec_stage
  import arm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  cond_exec_if.slave       bus,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] squashed_cnt
);
  logic       valid_e;
  logic [3:0] cond_e_q;
  logic       pcs_e, regw_e, memw_e, nowrite_e, shift_e;
  logic [1:0] flagw_e;
  logic [3:0] flags_q;
  logic       condpass;
  logic       cond_ex;
  logic       retire;

  cond_check u_cond_check (
    .Cond     (cond_e_q),
    .Flags    (flags_q),
    .condpass (condpass)
  );

  assign cond_ex      = valid_e & condpass;
  assign retire       = valid_e & ~bus.stall;
  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = cond_ex & pcs_e;
  assign bus.RegWrite = cond_ex & regw_e & ~nowrite_e;
  assign bus.MemWrite = cond_ex & memw_e;
  assign bus.Flags    = flags_q;

  // Flush only clears the valid bit; the payload is don't-care when empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_e   <= 1'b0;
      cond_e_q  <= 4'b0000;
      pcs_e     <= 1'b0;
      regw_e    <= 1'b0;
      memw_e    <= 1'b0;
      nowrite_e <= 1'b0;
      shift_e   <= 1'b0;
      flagw_e   <= 2'b00;
    end else if (bus.flush) begin
      valid_e <= 1'b0;
    end else if (!bus.stall) begin
      valid_e   <= bus.in_valid;
      cond_e_q  <= bus.Cond;
      pcs_e     <= bus.PCS;
      regw_e    <= bus.RegW;
      memw_e    <= bus.MemW;
      nowrite_e <= bus.NoWrite;
      shift_e   <= bus.Shift;
      flagw_e   <= bus.FlagW;
    end
  end

  // A flag-setting shift takes C from the shifter and leaves V alone,
  // overriding whatever FlagW says about C,V.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= 4'b0000;
    end else if (retire && cond_ex) begin
      if (flagw_e[FLAGW_NZ]) begin
        flags_q[FLAG_N] <= bus.ALUFlags[FLAG_N];
        flags_q[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
      end
      if (shift_e && flagw_e[FLAGW_NZ]) begin
        flags_q[FLAG_C] <= bus.ShiftCarry;
      end else if (flagw_e[FLAGW_CV]) begin
        flags_q[FLAG_C] <= bus.ALUFlags[FLAG_C];
        flags_q[FLAG_V] <= bus.ALUFlags[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_cnt  <= '0;
      squashed_cnt <= '0;
    end else if (retire) begin
      if (cond_ex) retired_cnt  <= retired_cnt + 1'b1;
      else         squashed_cnt <= squashed_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_cond_exec_stage.sv
// Bench for cond_exec_stage: directed scenarios with literal expectations
// followed by randomized traffic against a behavioural model.
module tb_cond_exec_stage;
  import arm_pkg::*;

  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic clk;
  logic reset_n;
  logic [CNT_W-1:0] retired_cnt, squashed_cnt;
  int errors = 0;
  int checks = 0;

  cond_exec_if bus ();

  cond_exec_stage #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .retired_cnt  (retired_cnt),
    .squashed_cnt (squashed_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model state
  bit       m_valid;
  bit [3:0] m_cond;
  bit       m_pcs, m_regw, m_memw, m_nowr, m_shift;
  bit [1:0] m_flagw;
  bit [3:0] m_flags;
  int       m_ret, m_sq;

  function automatic bit cond_holds(bit [3:0] cond, bit [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_condex();
    return m_valid && cond_holds(m_cond, m_flags);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_cond = 0; m_pcs = 0; m_regw = 0; m_memw = 0;
    m_nowr = 0; m_shift = 0; m_flagw = 0; m_flags = 0; m_ret = 0; m_sq = 0;
  endtask

  // One rising edge, as the rules describe it, using the currently driven inputs.
  task automatic model_edge();
    bit ce;
    bit [3:0] nf;
    ce = m_condex();
    if (m_valid && !bus.stall) begin
      if (ce) begin
        nf = m_flags;
        if (m_flagw[1]) begin
          nf[3] = bus.ALUFlags[3];
          nf[2] = bus.ALUFlags[2];
        end
        if (m_shift && m_flagw[1]) nf[1] = bus.ShiftCarry;
        else if (m_flagw[0]) begin
          nf[1] = bus.ALUFlags[1];
          nf[0] = bus.ALUFlags[0];
        end
        m_flags = nf;
        m_ret = (m_ret + 1) % CNT_MOD;
      end else begin
        m_sq = (m_sq + 1) % CNT_MOD;
      end
    end
    if (bus.flush) m_valid = 0;
    else if (!bus.stall) begin
      m_valid = bus.in_valid; m_cond = bus.Cond; m_pcs = bus.PCS;
      m_regw = bus.RegW; m_memw = bus.MemW; m_nowr = bus.NoWrite;
      m_shift = bus.Shift; m_flagw = bus.FlagW;
    end
  endtask

  // scoreboard
  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit ce;
    ce = m_condex();
    check("CondEx",   16'(bus.CondEx),   16'(ce));
    check("PCSrc",    16'(bus.PCSrc),    16'(ce && m_pcs));
    check("RegWrite", 16'(bus.RegWrite), 16'(ce && m_regw && !m_nowr));
    check("MemWrite", 16'(bus.MemWrite), 16'(ce && m_memw));
    check("Flags",    16'(bus.Flags),    16'(m_flags));
    check("retired",  16'(retired_cnt),  16'(m_ret));
    check("squashed", 16'(squashed_cnt), 16'(m_sq));
  endtask

  // driver tasks (called just after a falling edge)
  task automatic drive(bit iv, bit st, bit fl, bit [3:0] cond, bit pcs,
                       bit regw, bit memw, bit nowr, bit shift,
                       bit [1:0] flagw, bit [3:0] aluf, bit sc);
    bus.in_valid = iv; bus.stall = st; bus.flush = fl; bus.Cond = cond;
    bus.PCS = pcs; bus.RegW = regw; bus.MemW = memw; bus.NoWrite = nowr;
    bus.Shift = shift; bus.FlagW = flagw; bus.ALUFlags = aluf;
    bus.ShiftCarry = sc;
  endtask

  task automatic idle(bit [3:0] aluf = 4'b0, bit sc = 1'b0);
    drive(0, 0, 0, COND_AL, 0, 0, 0, 0, 0, 2'b00, aluf, sc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #2;
    check("rst_CondEx",   16'(bus.CondEx),  16'd0);
    check("rst_Flags",    16'(bus.Flags),   16'd0);
    check("rst_retired",  16'(retired_cnt), 16'd0);
    check("rst_squashed", 16'(squashed_cnt),16'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // reset then idle
    tick();
    check("idle_RegWrite", 16'(bus.RegWrite), 16'd0);
    check("idle_Flags",    16'(bus.Flags),    16'd0);

    // CMP (AL, FlagW=11, NoWrite) then BNE
    drive(1, 0, 0, COND_AL, 0, 1, 0, 1, 0, 2'b11, 4'b0, 0);
    tick();
    check("cmp_RegWrite", 16'(bus.RegWrite), 16'd0);
    check("cmp_CondEx",   16'(bus.CondEx),   16'd1);
    drive(1, 0, 0, COND_NE, 1, 0, 0, 0, 0, 2'b00, 4'b0100, 0);
    tick();
    check("bne_Flags",  16'(bus.Flags),  16'h4);
    check("bne_CondEx", 16'(bus.CondEx), 16'd0);
    check("bne_PCSrc",  16'(bus.PCSrc),  16'd0);
    idle();
    tick();
    check("bne_squashed", 16'(squashed_cnt), 16'd1);
    check("bne_retired",  16'(retired_cnt),  16'd1);

    // ADDS overflow then GE
    drive(1, 0, 0, COND_AL, 0, 1, 0, 0, 0, 2'b11, 4'b0, 0);
    tick();
    check("adds_RegWrite", 16'(bus.RegWrite), 16'd1);
    drive(1, 0, 0, COND_GE, 1, 1, 0, 0, 0, 2'b00, 4'b0011, 0);
    tick();
    check("adds_Flags", 16'(bus.Flags),  16'h3);
    check("ge_CondEx",  16'(bus.CondEx), 16'd0);
    idle();
    tick();

    // LSLS with prior V=1
    drive(1, 0, 0, COND_AL, 0, 1, 0, 0, 1, 2'b10, 4'b0, 0);
    tick();
    idle(4'b1000, 1'b1);
    tick();
    check("lsls_Flags", 16'(bus.Flags), 16'hB);
    check("lsls_retired", 16'(retired_cnt), 16'd3);

    // STR held under a 3-cycle stall
    drive(1, 0, 0, COND_AL, 0, 0, 1, 0, 0, 2'b00, 4'b0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, COND_AL, 1, 1, 0, 0, 0, 2'b11, 4'hF, 1);
      tick();
      check("stall_MemWrite", 16'(bus.MemWrite), 16'd1);
      check("stall_retired",  16'(retired_cnt),  16'd3);
      check("stall_Flags",    16'(bus.Flags),    16'hB);
    end
    idle();
    tick();
    check("str_retired", 16'(retired_cnt), 16'd4);

    // stall and flush together
    drive(1, 0, 0, COND_AL, 0, 0, 1, 0, 0, 2'b00, 4'b0, 0);
    tick();
    drive(1, 1, 1, COND_AL, 0, 1, 0, 0, 0, 2'b00, 4'b0, 0);
    tick();
    check("sf_CondEx",  16'(bus.CondEx),  16'd0);
    check("sf_retired", 16'(retired_cnt), 16'd4);
    idle();
    tick();
    check("sf_retired2", 16'(retired_cnt), 16'd4);

    // reset mid-stream drops the in-flight flag-setting instruction
    drive(1, 0, 0, COND_AL, 0, 1, 0, 0, 0, 2'b11, 4'hF, 1);
    tick();
    idle(4'hF, 1'b1);
    #1;
    do_reset();
    check("midrst_Flags", 16'(bus.Flags), 16'd0);

    // counter wrap: 16 AL instructions
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, COND_AL, 0, 1, 0, 0, 0, 2'b00, 4'b0, 0);
      tick();
    end
    check("wrap_15", 16'(retired_cnt), 16'd15);
    idle();
    tick();
    check("wrap_0", 16'(retired_cnt), 16'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
